// File: rtl/alu_reservation_station_pkg.sv
// ============================================================================
// Module   : alu_reservation_station_pkg
// Brief    : Opcode encodings and shared constants for the ALU reservation station.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_reservation_station_pkg;

    localparam logic [4:0] ADD    = 5'd0;
    localparam logic [4:0] SUB    = 5'd1;
    localparam logic [4:0] AND_OP = 5'd2;
    localparam logic [4:0] OR_OP  = 5'd3;
    localparam logic [4:0] XOR_OP = 5'd4;
    localparam logic [4:0] SLL    = 5'd5;
    localparam logic [4:0] SRL    = 5'd6;
    localparam logic [4:0] SRA    = 5'd7;
    localparam logic [4:0] SLT    = 5'd8;
    localparam logic [4:0] SLTU   = 5'd9;
    localparam logic [4:0] BEQ    = 5'd10;
    localparam logic [4:0] BNE    = 5'd11;
    localparam logic [4:0] BLT    = 5'd12;
    localparam logic [4:0] BGE    = 5'd13;
    localparam logic [4:0] BLTU   = 5'd14;
    localparam logic [4:0] BGEU   = 5'd15;
    localparam logic [4:0] JAL_C  = 5'd16;
    localparam logic [4:0] NOP_OP = 5'b11111;

    // Age stamps are 3 bits: enough to order up to 8 entries.
    localparam int AGE_W = 3;

endpackage

`default_nettype wire

// File: rtl/alu_reservation_station_rs_select.sv
// ============================================================================
// Module   : alu_reservation_station_rs_select
// Brief    : Combinational issue picker; one-hot grant over the ready vector.
//            RS_AGE_ORDER_EN selects the oldest (smallest age) ready entry,
//            otherwise the lowest index wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_reservation_station_rs_select
    import alu_reservation_station_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]       ready,
`ifdef RS_AGE_ORDER_EN
    input  logic [DEPTH*AGE_W-1:0] ages,
`endif
    output logic [DEPTH-1:0]       grant,
    output logic                   valid
);

`ifdef RS_AGE_ORDER_EN
    logic [AGE_W-1:0] w_best;

    always_comb begin
        grant  = '0;
        valid  = 1'b0;
        w_best = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!valid || ages[i*AGE_W +: AGE_W] < w_best)) begin
                grant    = '0;
                grant[i] = 1'b1;
                valid    = 1'b1;
                w_best   = ages[i*AGE_W +: AGE_W];
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !valid) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/alu_reservation_station.sv
// ============================================================================
// Module   : alu_reservation_station
// Brief    : Holds dispatched ALU/branch ops until operands are ready, snoops
//            ALU/memory broadcasts, issues one ready op per cycle.
//            Optional macro RS_AGE_ORDER_EN: oldest-first issue via age stamps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       op_in,
    input  logic [31:0]      value1_in,
    input  logic [31:0]      value2_in,
    input  logic [TAG_W-1:0] query1_in,
    input  logic [TAG_W-1:0] query2_in,
    input  logic             is_branch_in,
    input  logic [TAG_W-1:0] target_in,
    input  logic [TAG_W-1:0] alu_num,
    input  logic [31:0]      alu_value,
    input  logic [TAG_W-1:0] mem_num,
    input  logic [31:0]      mem_value,
    output logic             rs_full,
    output logic [4:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [TAG_W-1:0] alu_dest,
    output logic             alu_is_branch
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_br;
    logic [4:0]       r_op  [DEPTH];
    logic [31:0]      r_v1  [DEPTH];
    logic [31:0]      r_v2  [DEPTH];
    logic [TAG_W-1:0] r_q1  [DEPTH];
    logic [TAG_W-1:0] r_q2  [DEPTH];
    logic [TAG_W-1:0] r_tgt [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [DEPTH-1:0]    w_ready;
    logic [DEPTH-1:0]    w_grant;
    logic                w_issue;
    logic [DEPTH-1:0]    w_alloc_oh;
    logic                w_any_free;
    logic                w_alloc;
    logic                w_alloc_ok;
    logic [CNT_W-1:0]    w_count_next;
    logic [4:0]          w_iss_op;
    logic [31:0]         w_iss_a;
    logic [31:0]         w_iss_b;
    logic [TAG_W-1:0]    w_iss_tgt;
    logic                w_iss_br;
    logic [TAG_W+31:0]   w_in1;
    logic [TAG_W+31:0]   w_in2;
    logic [TAG_W+31:0]   w_wk1 [DEPTH];
    logic [TAG_W+31:0]   w_wk2 [DEPTH];

    // Returns {query, value} after snooping both broadcasts; memory wins a tie.
    function automatic logic [TAG_W+31:0] snoop(
        input logic [TAG_W-1:0] q,
        input logic [31:0]      v,
        input logic [TAG_W-1:0] a_num,
        input logic [31:0]      a_val,
        input logic [TAG_W-1:0] m_num,
        input logic [31:0]      m_val
    );
        if (q != '0 && q == m_num) return {{TAG_W{1'b0}}, m_val};
        if (q != '0 && q == a_num) return {{TAG_W{1'b0}}, a_val};
        return {q, v};
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_valid[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
            w_wk1[i]   = snoop(r_q1[i], r_v1[i], alu_num, alu_value, mem_num, mem_value);
            w_wk2[i]   = snoop(r_q2[i], r_v2[i], alu_num, alu_value, mem_num, mem_value);
        end
        w_in1 = snoop(query1_in, value1_in, alu_num, alu_value, mem_num, mem_value);
        w_in2 = snoop(query2_in, value2_in, alu_num, alu_value, mem_num, mem_value);
    end

    // Lowest free slot, judged on pre-issue occupancy.
    always_comb begin
        w_alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_oh    = '0;
                w_alloc_oh[i] = 1'b1;
            end
        end
    end

    assign w_any_free   = |(~r_valid);
    assign w_alloc      = (op_in != NOP_OP);
    assign w_alloc_ok   = w_alloc && w_any_free;
    assign w_count_next = r_count + CNT_W'(w_alloc_ok) - CNT_W'(w_issue);

`ifdef RS_AGE_ORDER_EN
    logic [AGE_W-1:0]       r_age [DEPTH];
    logic [DEPTH*AGE_W-1:0] w_ages;
    logic [AGE_W-1:0]       w_iss_age;
    logic [AGE_W-1:0]       w_new_age;

    for (genvar g = 0; g < DEPTH; g++) begin : g_age_pack
        assign w_ages[g*AGE_W +: AGE_W] = r_age[g];
    end

    always_comb begin
        w_iss_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) w_iss_age = r_age[i];
        end
    end

    // Stamp = number of entries that stay older than the newcomer.
    assign w_new_age = AGE_W'(r_count - CNT_W'(w_issue));
`endif

    alu_reservation_station_rs_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready (w_ready),
`ifdef RS_AGE_ORDER_EN
        .ages  (w_ages),
`endif
        .grant (w_grant),
        .valid (w_issue)
    );

    always_comb begin
        w_iss_op  = NOP_OP;
        w_iss_a   = '0;
        w_iss_b   = '0;
        w_iss_tgt = '0;
        w_iss_br  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_iss_op  = r_op[i];
                w_iss_a   = r_v1[i];
                w_iss_b   = r_v2[i];
                w_iss_tgt = r_tgt[i];
                w_iss_br  = r_br[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_count       <= '0;
            rs_full       <= 1'b0;
            alu_op        <= NOP_OP;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_dest      <= '0;
            alu_is_branch <= 1'b0;
        end else begin
            assert (!(w_alloc && !w_any_free));
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    {r_q1[i], r_v1[i]} <= w_wk1[i];
                    {r_q2[i], r_v2[i]} <= w_wk2[i];
                end
                if (w_grant[i]) r_valid[i] <= 1'b0;
`ifdef RS_AGE_ORDER_EN
                if (w_issue && r_valid[i] && r_age[i] > w_iss_age) r_age[i] <= r_age[i] - 1'b1;
                if (w_alloc_ok && w_alloc_oh[i]) r_age[i] <= w_new_age;
`endif
                if (w_alloc_ok && w_alloc_oh[i]) begin
                    r_valid[i]         <= 1'b1;
                    r_op[i]            <= op_in;
                    r_br[i]            <= is_branch_in;
                    r_tgt[i]           <= target_in;
                    {r_q1[i], r_v1[i]} <= w_in1;
                    {r_q2[i], r_v2[i]} <= w_in2;
                end
            end
            r_count       <= w_count_next;
            rs_full       <= (w_count_next >= CNT_W'(DEPTH - 1));
            alu_op        <= w_iss_op;
            alu_a         <= w_iss_a;
            alu_b         <= w_iss_b;
            alu_dest      <= w_iss_tgt;
            alu_is_branch <= w_iss_br;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
// ============================================================================
// Module   : tb_alu_reservation_station
// Brief    : Directed scenarios plus randomized traffic against a slot/sequence
//            reference model. Honors RS_AGE_ORDER_EN for issue ordering.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;
    localparam int OUT_W = 5 + 32 + 32 + TAG_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       op_in;
    logic [31:0]      value1_in, value2_in;
    logic [TAG_W-1:0] query1_in, query2_in, target_in;
    logic             is_branch_in;
    logic [TAG_W-1:0] alu_num, mem_num;
    logic [31:0]      alu_value, mem_value;
    logic             rs_full;
    logic [4:0]       alu_op;
    logic [31:0]      alu_a, alu_b;
    logic [TAG_W-1:0] alu_dest;
    logic             alu_is_branch;

    int checks = 0;
    int errors = 0;

    // Reference model: slots with a global dispatch sequence number for age.
    logic             m_valid [DEPTH];
    logic [4:0]       m_op    [DEPTH];
    logic [31:0]      m_v1    [DEPTH];
    logic [31:0]      m_v2    [DEPTH];
    logic [TAG_W-1:0] m_q1    [DEPTH];
    logic [TAG_W-1:0] m_q2    [DEPTH];
    logic [TAG_W-1:0] m_tgt   [DEPTH];
    logic             m_br    [DEPTH];
    int unsigned      m_seq   [DEPTH];
    int unsigned      seq_ctr = 0;
    int               m_count = 0;
    logic [OUT_W-1:0] exp_out;
    logic             exp_full;

    always #5 clk = ~clk;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .op_in(op_in), .value1_in(value1_in), .value2_in(value2_in),
        .query1_in(query1_in), .query2_in(query2_in), .is_branch_in(is_branch_in),
        .target_in(target_in), .alu_num(alu_num), .alu_value(alu_value),
        .mem_num(mem_num), .mem_value(mem_value), .rs_full(rs_full), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_dest(alu_dest), .alu_is_branch(alu_is_branch)
    );

    function automatic logic [TAG_W+31:0] bcast(input logic [TAG_W-1:0] q, input logic [31:0] v);
        if (q != 0 && q == mem_num) return {{TAG_W{1'b0}}, mem_value};
        if (q != 0 && q == alu_num) return {{TAG_W{1'b0}}, alu_value};
        return {q, v};
    endfunction

    task automatic model_step();
        int pick;
        int slot;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            m_count  = 0;
            exp_out  = {NOP_OP, {(OUT_W-5){1'b0}}};
            exp_full = 1'b0;
            return;
        end
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_q1[i] == 0 && m_q2[i] == 0) begin
`ifdef RS_AGE_ORDER_EN
                if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        if (pick >= 0) exp_out = {m_op[pick], m_v1[pick], m_v2[pick], m_tgt[pick], m_br[pick]};
        else           exp_out = {NOP_OP, {(OUT_W-5){1'b0}}};
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i]) begin
                {m_q1[i], m_v1[i]} = bcast(m_q1[i], m_v1[i]);
                {m_q2[i], m_v2[i]} = bcast(m_q2[i], m_v2[i]);
            end
        end
        slot = -1;
        if (op_in != NOP_OP)
            for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && slot < 0) slot = i;
        if (pick >= 0) begin
            m_valid[pick] = 1'b0;
            m_count--;
        end
        if (slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_op[slot]    = op_in;
            m_tgt[slot]   = target_in;
            m_br[slot]    = is_branch_in;
            {m_q1[slot], m_v1[slot]} = bcast(query1_in, value1_in);
            {m_q2[slot], m_v2[slot]} = bcast(query2_in, value2_in);
            m_seq[slot]   = seq_ctr++;
            m_count++;
        end
        exp_full = (m_count >= DEPTH - 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        op_in = NOP_OP; value1_in = '0; value2_in = '0; query1_in = '0; query2_in = '0;
        is_branch_in = 1'b0; target_in = '0;
        alu_num = '0; alu_value = '0; mem_num = '0; mem_value = '0;
    endtask

    task automatic dispatch(input logic [4:0] op, input logic [TAG_W-1:0] q1, input logic [31:0] v1,
                            input logic [TAG_W-1:0] q2, input logic [31:0] v2,
                            input logic br, input logic [TAG_W-1:0] tgt);
        op_in = op; query1_in = q1; value1_in = v1; query2_in = q2; value2_in = v2;
        is_branch_in = br; target_in = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        tick();
        tick();
        checks++;
        if ({alu_op, alu_dest, alu_is_branch, rs_full} !== {NOP_OP, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got op=%h dest=%0d br=%b full=%b, want op=1f dest=0 br=0 full=0",
                     alu_op, alu_dest, alu_is_branch, rs_full);
        end
        checks++;
        if ({alu_a, alu_b} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h want 0", alu_a, alu_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_issue();
        dispatch(ADD, 0, 32'd5, 0, 32'd7, 1'b0, 3'd3);
        tick();
        set_idle();
        checks++;
        if (alu_op !== NOP_OP) begin
            errors++;
            $display("FAIL add_early: got op=%h want 1f", alu_op);
        end
        tick();
        checks++;
        if ({alu_op, alu_a, alu_b, alu_dest} !== {ADD, 32'd5, 32'd7, 3'd3}) begin
            errors++;
            $display("FAIL add_issue: got op=%h a=%0d b=%0d dest=%0d want op=0 a=5 b=7 dest=3",
                     alu_op, alu_a, alu_b, alu_dest);
        end
        tick();
        checks++;
        if (alu_op !== NOP_OP || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL add_after: got op=%h full=%b want op=1f full=0", alu_op, rs_full);
        end
    endtask

    task automatic test_wakeup();
        dispatch(SUB, 3'd2, 32'd0, 0, 32'd1, 1'b0, 3'd4);
        tick();
        set_idle();
        tick();
        checks++;
        if (alu_op !== NOP_OP) begin
            errors++;
            $display("FAIL wake_blocked: got op=%h want 1f", alu_op);
        end
        alu_num = 3'd2; alu_value = 32'd10;
        tick();
        set_idle();
        checks++;
        if (alu_op !== NOP_OP) begin
            errors++;
            $display("FAIL wake_latency: got op=%h want 1f", alu_op);
        end
        tick();
        checks++;
        if ({alu_op, alu_a, alu_b, alu_dest} !== {SUB, 32'd10, 32'd1, 3'd4}) begin
            errors++;
            $display("FAIL wake_issue: got op=%h a=%0d b=%0d dest=%0d want op=1 a=10 b=1 dest=4",
                     alu_op, alu_a, alu_b, alu_dest);
        end
        tick();
    endtask

    task automatic test_bypass();
        dispatch(ADD, 0, 32'd3, 3'd4, 32'd0, 1'b1, 3'd5);
        mem_num = 3'd4; mem_value = 32'hDEAD;
        tick();
        set_idle();
        tick();
        checks++;
        if ({alu_op, alu_a, alu_b, alu_dest, alu_is_branch} !== {ADD, 32'd3, 32'hDEAD, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL bypass_issue: got op=%h a=%h b=%h dest=%0d br=%b want op=0 a=3 b=dead dest=5 br=1",
                     alu_op, alu_a, alu_b, alu_dest, alu_is_branch);
        end
        tick();
    endtask

    task automatic test_full();
        dispatch(ADD, 3'd5, 0, 0, 32'd1, 1'b0, 3'd1);
        tick();
        dispatch(ADD, 3'd6, 0, 0, 32'd2, 1'b0, 3'd2);
        tick();
        checks++;
        if (rs_full !== 1'b0) begin
            errors++;
            $display("FAIL full_two: got %b want 0", rs_full);
        end
        dispatch(ADD, 3'd7, 0, 0, 32'd3, 1'b0, 3'd3);
        tick();
        checks++;
        if (rs_full !== 1'b1) begin
            errors++;
            $display("FAIL full_three: got %b want 1", rs_full);
        end
        set_idle();
        alu_num = 3'd5; alu_value = 32'd100;
        tick();
        set_idle();
        checks++;
        if (rs_full !== 1'b1 || alu_op !== NOP_OP) begin
            errors++;
            $display("FAIL full_wake: got full=%b op=%h want full=1 op=1f", rs_full, alu_op);
        end
        tick();
        checks++;
        if (rs_full !== 1'b0 || alu_dest !== 3'd1 || alu_a !== 32'd100) begin
            errors++;
            $display("FAIL full_release: got full=%b dest=%0d a=%0d want full=0 dest=1 a=100",
                     rs_full, alu_dest, alu_a);
        end
        alu_num = 3'd6; mem_num = 3'd7;
        tick();
        set_idle();
        tick();
        checks++;
        if (alu_dest !== 3'd2) begin
            errors++;
            $display("FAIL full_drain1: got dest=%0d want 2", alu_dest);
        end
        tick();
        checks++;
        if (alu_dest !== 3'd3) begin
            errors++;
            $display("FAIL full_drain2: got dest=%0d want 3", alu_dest);
        end
        tick();
    endtask

    task automatic test_order();
        logic [TAG_W-1:0] first_dest;
        logic [TAG_W-1:0] second_dest;
`ifdef RS_AGE_ORDER_EN
        first_dest = 3'd3; second_dest = 3'd4;
`else
        first_dest = 3'd4; second_dest = 3'd3;
`endif
        dispatch(ADD, 3'd4, 0, 0, 0, 1'b0, 3'd1);
        tick();
        dispatch(ADD, 3'd6, 0, 0, 0, 1'b0, 3'd2);
        tick();
        dispatch(ADD, 3'd5, 0, 0, 0, 1'b0, 3'd3);
        tick();
        set_idle();
        alu_num = 3'd4;
        tick();
        set_idle();
        tick();
        checks++;
        if (alu_dest !== 3'd1) begin
            errors++;
            $display("FAIL order_first_slot: got dest=%0d want 1", alu_dest);
        end
        dispatch(SUB, 3'd7, 0, 0, 0, 1'b0, 3'd4);
        tick();
        set_idle();
        alu_num = 3'd5; mem_num = 3'd7;
        tick();
        set_idle();
        tick();
        checks++;
        if (alu_dest !== first_dest) begin
            errors++;
            $display("FAIL order_pick1: got dest=%0d want %0d", alu_dest, first_dest);
        end
        tick();
        checks++;
        if (alu_dest !== second_dest) begin
            errors++;
            $display("FAIL order_pick2: got dest=%0d want %0d", alu_dest, second_dest);
        end
        alu_num = 3'd6;
        tick();
        set_idle();
        tick();
        checks++;
        if (alu_dest !== 3'd2) begin
            errors++;
            $display("FAIL order_drain: got dest=%0d want 2", alu_dest);
        end
        tick();
    endtask

    task automatic test_flush();
        dispatch(ADD, 3'd5, 0, 0, 0, 1'b0, 3'd1);
        tick();
        dispatch(ADD, 3'd6, 0, 0, 0, 1'b0, 3'd2);
        tick();
        dispatch(XOR_OP, 0, 32'd9, 0, 32'd9, 1'b0, 3'd3);
        tick();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (alu_op !== NOP_OP || alu_dest !== 3'd0 || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL flush_now: got op=%h dest=%0d full=%b want op=1f dest=0 full=0",
                     alu_op, alu_dest, rs_full);
        end
        alu_num = 3'd5; mem_num = 3'd6;
        tick();
        set_idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (alu_op !== NOP_OP || alu_dest !== 3'd0) begin
                errors++;
                $display("FAIL flush_stale: cycle %0d got op=%h dest=%0d want op=1f dest=0",
                         k, alu_op, alu_dest);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 440; cyc++) begin
            set_idle();
            if (cyc < 400 && !exp_full && $urandom_range(0, 2) != 0) begin
                dispatch(5'($urandom_range(0, 16)),
                         ($urandom_range(0, 1) != 0) ? TAG_W'($urandom_range(1, 7)) : '0, $urandom(),
                         ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : '0, $urandom(),
                         1'($urandom_range(0, 1)), TAG_W'($urandom_range(1, 7)));
            end
            if (cyc < 400) begin
                alu_num = TAG_W'($urandom_range(0, 7));
                mem_num = TAG_W'($urandom_range(0, 7));
            end else begin
                alu_num = TAG_W'((cyc % 7) + 1);
                mem_num = TAG_W'(((cyc + 3) % 7) + 1);
            end
            if (mem_num == alu_num) mem_num = '0;
            alu_value = $urandom();
            mem_value = $urandom();
            tick();
            checks++;
            if ({alu_op, alu_a, alu_b, alu_dest, alu_is_branch} !== exp_out) begin
                errors++;
                $display("FAIL rand_issue: cycle %0d got %h want %h", cyc,
                         {alu_op, alu_a, alu_b, alu_dest, alu_is_branch}, exp_out);
            end
            checks++;
            if (rs_full !== exp_full) begin
                errors++;
                $display("FAIL rand_full: cycle %0d got %b want %b", cyc, rs_full, exp_full);
            end
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_order();
        test_flush();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
